// File: rtl/stepper_pkg.sv
// stepper_pkg: phase codes, index decode and FSM states shared by the stepper driver and decoder
package stepper_pkg;
  localparam logic [3:0] PH_0 = 4'b0111;
  localparam logic [3:0] PH_1 = 4'b1011;
  localparam logic [3:0] PH_2 = 4'b1101;
  localparam logic [3:0] PH_3 = 4'b1110;
  localparam logic [3:0] PH_NONE = 4'b1111;
  typedef enum logic {S_SEARCH, S_TRACK} state_t;
  function automatic logic [2:0] phase_to_idx(input logic [3:0] p);
    return p == PH_0 ? 3'b100 : p == PH_1 ? 3'b101 : p == PH_2 ? 3'b110 : p == PH_3 ? 3'b111 : 3'b000;
  endfunction
endpackage

// File: rtl/stepper_phase_decoder_if.sv
// stepper_phase_decoder_if: phase bus, clear controls and decoder status
interface stepper_phase_decoder_if #(parameter int POS_W = 16);
  logic [3:0] phase;
  logic clr_pos;
  logic clr_err;
  logic [POS_W-1:0] position;
  logic dir;
  logic step_pulse;
  logic locked;
  logic err_skip;
  logic err_illegal;
  logic stalled;
  modport master(output phase, clr_pos, clr_err,
                 input position, dir, step_pulse, locked, err_skip, err_illegal, stalled);
  modport slave(input phase, clr_pos, clr_err,
                output position, dir, step_pulse, locked, err_skip, err_illegal, stalled);
endinterface

// File: rtl/stepper_phase_decoder_phase_filter.sv
// phase_filter: two-flop sync of the phase bus plus a stability filter that fires once per held pattern
module phase_filter #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] phase,
  output logic [3:0] cand,
  output logic       stable
);
  localparam int CW = STABLE_CYCLES > 1 ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  logic [3:0] s1, s2;
  logic [CW-1:0] cnt;
  logic fired;
  // fired keeps a held pattern from being offered again after its first stable cycle
  assign stable = s2 == cand && cnt == LAST && !fired;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 4'b1111;
      s2 <= 4'b1111;
      cand <= 4'b1111;
      cnt <= '0;
      fired <= 1'b0;
    end else begin
      s1 <= phase;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        cnt <= '0;
        fired <= 1'b0;
      end else begin
        if (cnt < LAST) cnt <= cnt + 1'b1;
        if (stable) fired <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/stepper_phase_decoder.sv
// stepper_phase_decoder: recovers direction and signed position from the one-cold coil phase bus,
// flagging skips, illegal codes and stalls
module stepper_phase_decoder
  import stepper_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int POS_W = 16,
  parameter int STALL_CYCLES = 1000000
) (
  input logic clk,
  input logic rst_n,
  stepper_phase_decoder_if.slave bus
);
  localparam int SW = $clog2(STALL_CYCLES + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_CYCLES);
  state_t state, state_nx;
  logic [3:0] cand, ref_ph, ref_nx;
  logic stable, accept, up, dn, skip, ill, step;
  logic [2:0] ci, ri;
  logic [1:0] d;
  logic [POS_W-1:0] pos;
  logic [SW-1:0] stall_cnt;
  logic dir, step_pulse, err_skip, err_illegal;
  phase_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filt (
    .clk(clk), .rst_n(rst_n), .phase(bus.phase), .cand(cand), .stable(stable)
  );
  assign ci = phase_to_idx(cand);
  assign ri = phase_to_idx(ref_ph);
  assign d = ci[1:0] - ri[1:0];
  assign accept = stable && cand != ref_ph;
  assign step = up | dn;
  always_comb begin
    state_nx = state;
    ref_nx = ref_ph;
    up = 1'b0;
    dn = 1'b0;
    skip = 1'b0;
    ill = 1'b0;
    if (accept) begin
      if (!ci[2]) begin
        ill = 1'b1;
        state_nx = S_SEARCH;
        ref_nx = PH_NONE;
      end else if (state == S_TRACK && ri[2]) begin
        ref_nx = cand;
        up = d == 2'd1;
        dn = d == 2'd3;
        skip = d == 2'd2;
      end else begin
        state_nx = S_TRACK;
        ref_nx = cand;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_SEARCH;
      ref_ph <= PH_NONE;
      pos <= '0;
      dir <= 1'b0;
      step_pulse <= 1'b0;
      err_skip <= 1'b0;
      err_illegal <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      ref_ph <= ref_nx;
      step_pulse <= step;
      if (step) dir <= up;
      pos <= bus.clr_pos ? '0 : up ? pos + 1'b1 : dn ? pos - 1'b1 : pos;
      err_skip <= (err_skip & ~bus.clr_err) | skip;
      err_illegal <= (err_illegal & ~bus.clr_err) | ill;
      // counts only cycles spent wholly in TRACK; entering, leaving or stepping restarts it
      stall_cnt <= (state != S_TRACK || state_nx != S_TRACK || step) ? '0 :
                   stall_cnt == STALL_MAX ? stall_cnt : stall_cnt + 1'b1;
    end
  end
  assign bus.position = pos;
  assign bus.dir = dir;
  assign bus.step_pulse = step_pulse;
  assign bus.locked = state == S_TRACK;
  assign bus.err_skip = err_skip;
  assign bus.err_illegal = err_illegal;
  assign bus.stalled = stall_cnt == STALL_MAX;
endmodule

// File: tb/tb_stepper_phase_decoder.sv
// tb_stepper_phase_decoder: scoreboard bench; expected steps queued at drive time, popped on step_pulse
module tb_stepper_phase_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  logic [15:0] mpos = '0;
  typedef struct {
    logic [15:0] pos;
    logic dir;
    int cyc;
  } exp_t;
  exp_t q[$];
  stepper_phase_decoder_if #(.POS_W(16)) bus ();
  stepper_phase_decoder_if #(.POS_W(8)) bus8 ();
  stepper_phase_decoder #(.STABLE_CYCLES(4), .POS_W(16), .STALL_CYCLES(50)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  stepper_phase_decoder #(.STABLE_CYCLES(4), .POS_W(8), .STALL_CYCLES(50)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8)
  );
  assign bus8.phase = bus.phase;
  assign bus8.clr_pos = bus.clr_pos;
  assign bus8.clr_err = bus.clr_err;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  function automatic logic [3:0] code(input int i);
    logic [3:0] t [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    return t[i & 3];
  endfunction
  task automatic drv(input logic [3:0] p, input int delta, input int hold);
    bus.phase = p;
    if (delta != 0) begin
      mpos = mpos + 16'(delta);
      q.push_back('{mpos, delta > 0, cyc + 7});
    end
    tick(hold);
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pos"}, bus.position, 0);
    chk({tag, "_dir"}, bus.dir, 0);
    chk({tag, "_pulse"}, bus.step_pulse, 0);
    chk({tag, "_locked"}, bus.locked, 0);
    chk({tag, "_skip"}, bus.err_skip, 0);
    chk({tag, "_ill"}, bus.err_illegal, 0);
    chk({tag, "_stall"}, bus.stalled, 0);
    chk({tag, "_pos8"}, bus8.position, 0);
  endtask
  always @(negedge clk) begin
    if (rst_n && bus.step_pulse) begin
      if (q.size() == 0) chk("spurious_pulse", 1, 0);
      else begin
        automatic exp_t e = q.pop_front();
        chk("pulse_pos", bus.position, e.pos);
        chk("pulse_dir", bus.dir, e.dir);
        chk("pulse_lat", cyc, e.cyc);
        chk("pulse_stall", bus.stalled, 0);
      end
    end
  end
  initial begin
    bus.phase = 4'b0111;
    bus.clr_pos = 1'b0;
    bus.clr_err = 1'b0;
    tick(3);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    drv(4'b0111, 0, 10);
    chk("lock", bus.locked, 1);
    chk("lock_pos", bus.position, 0);
    for (int i = 1; i <= 4; i++) drv(code(i), 1, 10);
    chk("fwd_pos", bus.position, 4);
    chk("fwd_dir", bus.dir, 1);
    chk("fwd_q", q.size(), 0);
    drv(4'b1011, 1, 10);
    drv(4'b1101, 0, 3);
    drv(4'b1011, 0, 10);
    chk("glitch_pos", bus.position, 5);
    drv(4'b0111, -1, 10);
    drv(4'b1101, 0, 10);
    chk("skip_flag", bus.err_skip, 1);
    chk("skip_pos", bus.position, 4);
    drv(4'b1110, 1, 10);
    chk("after_skip_pos", bus.position, 5);
    drv(4'b0011, 0, 10);
    chk("ill_flag", bus.err_illegal, 1);
    chk("ill_locked", bus.locked, 0);
    chk("ill_pos", bus.position, 5);
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    chk("clr_skip", bus.err_skip, 0);
    chk("clr_ill", bus.err_illegal, 0);
    tick(2);
    chk("clr_hold_ill", bus.err_illegal, 0);
    bus.phase = 4'b0111;
    for (int i = 0; i < 20 && !bus.locked; i++) tick(1);
    chk("relock", bus.locked, 1);
    chk("relock_pos", bus.position, 5);
    tick(49);
    chk("stall_pre", bus.stalled, 0);
    tick(1);
    chk("stall_set", bus.stalled, 1);
    drv(4'b1011, 1, 10);
    chk("stall_clr", bus.stalled, 0);
    bus.phase = 4'b1101;
    mpos = 16'h0;
    q.push_back('{16'h0, 1'b1, cyc + 7});
    tick(6);
    bus.clr_pos = 1'b1;
    tick(1);
    bus.clr_pos = 1'b0;
    chk("clrpos_pulse", bus.step_pulse, 1);
    chk("clrpos_pos", bus.position, 0);
    tick(9);
    chk("pre_rst_q", q.size(), 0);
    bus.phase = 4'b1110;
    tick(3);
    rst_n = 1'b0;
    tick(2);
    chk_reset_outputs("midrst");
    rst_n = 1'b1;
    mpos = '0;
    drv(4'b1110, 0, 10);
    chk("rst_relock", bus.locked, 1);
    chk("rst_relock_pos", bus.position, 0);
    drv(4'b0111, 1, 10);
    drv(4'b1110, -1, 10);
    drv(4'b1101, -1, 10);
    chk("rev_pos", bus.position, 16'hFFFF);
    chk("rev_dir", bus.dir, 0);
    chk("rev_pos8", bus8.position, 8'hFF);
    for (int i = 3; i < 3 + 128; i++) drv(code(i), 1, 5);
    tick(5);
    chk("wrap_pre8", bus8.position, 8'h7F);
    drv(code(131), 1, 10);
    chk("wrap_pos8", bus8.position, 8'h80);
    chk("wrap_pos16", bus.position, 16'h0080);
    tick(10);
    chk("final_q", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout: run did not finish within bound");
    $fatal(1);
  end
endmodule
